// File: rtl/dmem_pkg.sv
// Shared types, I/O map offsets and address decode for the dual-port data memory responder.
package dmem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_LED,
    RGN_SW,
    RGN_CYC,
    RGN_NONE
  } region_e;

  localparam logic [15:0] LED_OFS = 16'd0;
  localparam logic [15:0] SW_OFS  = 16'd1;
  localparam logic [15:0] CYC_OFS = 16'd2;

  localparam int LED_W = 8;
  localparam int SW_W  = 8;

  // Addresses are zero-extended to 16 bits so one helper serves any port width up to 16.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input logic [15:0] depth,
                                            input logic [15:0] io_base);
    region_e rgn;
    rgn = RGN_NONE;
    if (addr < depth)                   rgn = RGN_RAM;
    else if (addr == io_base + LED_OFS) rgn = RGN_LED;
    else if (addr == io_base + SW_OFS)  rgn = RGN_SW;
    else if (addr == io_base + CYC_OFS) rgn = RGN_CYC;
    return rgn;
  endfunction

endpackage

// File: rtl/dmem_io_regs.sv
// Memory-mapped LED / switch / cycle-counter registers shared by both data ports.
// Read outputs are combinational next-rdata values; they are zero for non-I/O addresses.
module dmem_io_regs
  import dmem_pkg::*;
#(
  parameter int                ADDR_W  = 9,
  parameter int                DATA_W  = 16,
  parameter int                DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_BASE = 9'h100
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  input  logic              i_p0_we,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  input  logic              i_p1_we,
  input  logic [SW_W-1:0]   i_sw,
  output logic [DATA_W-1:0] o_p0_rdata,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic [LED_W-1:0]  o_led
);

  localparam logic [DATA_W-1:0] CYC_ONE = DATA_W'(1);

  region_e            w_rgn0;
  region_e            w_rgn1;
  logic               w_wr0_led;
  logic               w_wr1_led;
  logic               w_wr0_cyc;
  logic               w_wr1_cyc;
  logic [LED_W-1:0]   w_led_view;

  logic [LED_W-1:0]   r_led;
  logic [DATA_W-1:0]  r_cyc;
  logic [SW_W-1:0]    r_sw_s1;
  logic [SW_W-1:0]    r_sw_s2;

  assign w_rgn0 = decode_region(16'(i_p0_addr), 16'(DEPTH), 16'(IO_BASE));
  assign w_rgn1 = decode_region(16'(i_p1_addr), 16'(DEPTH), 16'(IO_BASE));

  assign w_wr0_led = i_run & i_p0_we & (w_rgn0 == RGN_LED);
  assign w_wr1_led = i_run & i_p1_we & (w_rgn1 == RGN_LED);
  assign w_wr0_cyc = i_run & i_p0_we & (w_rgn0 == RGN_CYC);
  assign w_wr1_cyc = i_run & i_p1_we & (w_rgn1 == RGN_CYC);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_led   <= '0;
      r_cyc   <= '0;
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= i_sw;
      r_sw_s2 <= r_sw_s1;

      if (w_wr1_led)      r_led <= i_p1_wdata[LED_W-1:0];
      else if (w_wr0_led) r_led <= i_p0_wdata[LED_W-1:0];

      // A load beats the free-running increment in the same cycle.
      if (!i_run)         r_cyc <= '0;
      else if (w_wr1_cyc) r_cyc <= i_p1_wdata;
      else if (w_wr0_cyc) r_cyc <= i_p0_wdata;
      else                r_cyc <= r_cyc + CYC_ONE;
    end
  end

  // LED reads are write-first; CYC reads return the value held before the edge.
  assign w_led_view = w_wr1_led ? i_p1_wdata[LED_W-1:0] :
                      w_wr0_led ? i_p0_wdata[LED_W-1:0] : r_led;

  function automatic logic [DATA_W-1:0] io_mux(input region_e          rgn,
                                               input logic [LED_W-1:0] led,
                                               input logic [SW_W-1:0]  sw,
                                               input logic [DATA_W-1:0] cyc);
    logic [DATA_W-1:0] v;
    v = '0;
    case (rgn)
      RGN_LED: v = {{(DATA_W-LED_W){1'b0}}, led};
      RGN_SW:  v = {{(DATA_W-SW_W){1'b0}}, sw};
      RGN_CYC: v = cyc;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign o_p0_rdata = io_mux(w_rgn0, w_led_view, r_sw_s2, r_cyc);
  assign o_p1_rdata = io_mux(w_rgn1, w_led_view, r_sw_s2, r_cyc);
  assign o_led      = r_led;

endmodule

// File: rtl/dmem_responder.sv
// Dual-port data-memory responder: shared RAM with zero-fill sweep after reset,
// plus the I/O register block. Both ports are serviced every cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | zero-fill RAM[init_ctr], port writes ignored, rdata held 0
//   ST_RUN  | normal service, mem_ready=1, left only by reset
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                ADDR_W  = 9,
  parameter int                DATA_W  = 16,
  parameter int                DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_BASE = 9'h100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_maddr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_write_mem,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic [ADDR_W-1:0] p1_maddr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_write_mem,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              mem_ready
);

  localparam int                RAM_AW   = $clog2(DEPTH);
  localparam logic [RAM_AW-1:0] LAST_IDX = RAM_AW'(DEPTH - 1);
  localparam logic [RAM_AW-1:0] CTR_ONE  = RAM_AW'(1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_run;
  logic [RAM_AW-1:0]  r_init_ctr;
  logic               r_ready;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_p0_rdata;
  logic [DATA_W-1:0]  r_p1_rdata;

  region_e            w_rgn0;
  region_e            w_rgn1;
  logic [RAM_AW-1:0]  w_idx0;
  logic [RAM_AW-1:0]  w_idx1;
  logic               w_wr0_ram;
  logic               w_wr1_ram;
  logic [DATA_W-1:0]  w_ram_rd0;
  logic [DATA_W-1:0]  w_ram_rd1;
  logic [DATA_W-1:0]  w_io_rd0;
  logic [DATA_W-1:0]  w_io_rd1;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_INIT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_INIT: if (r_init_ctr == LAST_IDX) w_state_nxt = ST_RUN;
      ST_RUN:  w_run = 1'b1;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // mem_ready rises on the same edge that writes the last sweep word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_init_ctr <= '0;
      r_ready    <= 1'b0;
    end else begin
      if (r_state == ST_INIT) r_init_ctr <= r_init_ctr + CTR_ONE;
      r_ready <= (w_state_nxt == ST_RUN);
    end
  end

  assign w_rgn0 = decode_region(16'(p0_maddr), 16'(DEPTH), 16'(IO_BASE));
  assign w_rgn1 = decode_region(16'(p1_maddr), 16'(DEPTH), 16'(IO_BASE));
  assign w_idx0 = p0_maddr[RAM_AW-1:0];
  assign w_idx1 = p1_maddr[RAM_AW-1:0];

  assign w_wr0_ram = w_run & p0_write_mem & (w_rgn0 == RGN_RAM);
  assign w_wr1_ram = w_run & p1_write_mem & (w_rgn1 == RGN_RAM);

  // p1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == ST_INIT) begin
        r_mem[r_init_ctr] <= '0;
      end else begin
        if (w_wr0_ram) r_mem[w_idx0] <= p0_wdata;
        if (w_wr1_ram) r_mem[w_idx1] <= p1_wdata;
      end
    end
  end

  always_comb begin
    w_ram_rd0 = r_mem[w_idx0];
    if (w_wr1_ram && (w_idx1 == w_idx0)) w_ram_rd0 = p1_wdata;
    else if (w_wr0_ram)                  w_ram_rd0 = p0_wdata;

    w_ram_rd1 = r_mem[w_idx1];
    if (w_wr1_ram)                            w_ram_rd1 = p1_wdata;
    else if (w_wr0_ram && (w_idx0 == w_idx1)) w_ram_rd1 = p0_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else if (w_run) begin
      r_p0_rdata <= (w_rgn0 == RGN_RAM) ? w_ram_rd0 : w_io_rd0;
      r_p1_rdata <= (w_rgn1 == RGN_RAM) ? w_ram_rd1 : w_io_rd1;
    end else begin
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end
  end

  dmem_io_regs #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .IO_BASE (IO_BASE)
  ) u_io_regs (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_run      (w_run),
    .i_p0_addr  (p0_maddr),
    .i_p0_wdata (p0_wdata),
    .i_p0_we    (p0_write_mem),
    .i_p1_addr  (p1_maddr),
    .i_p1_wdata (p1_wdata),
    .i_p1_we    (p1_write_mem),
    .i_sw       (sw_in),
    .o_p0_rdata (w_io_rd0),
    .o_p1_rdata (w_io_rd1),
    .o_led      (led_out)
  );

  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign mem_ready = r_ready;

endmodule
